// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at launch and held pending until the busy period ends.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        launch;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  assign launch = (state_q == StIdle) && Start && (MDOp >= 3'd1) && (MDOp <= 3'd4);

  // Operands are widened to 64 bits so the low half of the product holds the full result.
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};
  assign quot_s = (B != 32'b0) ? 32'($signed(A) / $signed(B)) : 32'b0;
  assign rem_s  = (B != 32'b0) ? 32'($signed(A) % $signed(B)) : 32'b0;
  assign quot_u = (B != 32'b0) ? A / B : 32'b0;
  assign rem_u  = (B != 32'b0) ? A % B : 32'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      phi_q   <= 32'b0;
      plo_q   <= 32'b0;
      hi_q    <= 32'b0;
      lo_q    <= 32'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StRun;
          cnt_d   = (MDOp <= 3'd2) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          case (MDOp)
            3'd1: {phi_d, plo_d} = prod_s;
            3'd2: {phi_d, plo_d} = prod_u;
            3'd3: begin
              // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
              phi_d = (B != 32'b0) ? rem_s  : hi_q;
              plo_d = (B != 32'b0) ? quot_s : lo_q;
            end
            default: begin
              phi_d = (B != 32'b0) ? rem_u  : hi_q;
              plo_d = (B != 32'b0) ? quot_u : lo_q;
            end
          endcase
        end else if (MDOp == 3'd5) begin
          hi_d = A;
        end else if (MDOp == 3'd6) begin
          lo_d = A;
        end
      end
      StRun: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_comb begin
    Busy = (state_q == StRun);
    HI   = hi_q;
    LO   = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected commits, a
// negedge monitor checks busy length, HI/LO hold during busy and committed values.
module tb_mult_div_unit;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] A = 32'b0, B = 32'b0;
  logic        Busy;
  logic [31:0] HI, LO;

  mult_div_unit #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] old_hi, old_lo, new_hi, new_lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = 32'b0, m_lo = 32'b0;
  int          tests = 0, fails = 0;
  int          busy_cnt = 0;
  logic        prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts busy cycles and checks the oldest pending operation.
  always @(negedge clk) begin
    exp_t e;
    if (Busy === 1'b1) begin
      busy_cnt++;
      if (sb.size() > 0) begin
        check("hold_hi", HI, sb[0].old_hi);
        check("hold_lo", LO, sb[0].old_lo);
      end
    end else if (prev_busy) begin
      if (sb.size() == 0) begin
        check("orphan_busy", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("busy_len", 32'(busy_cnt), 32'(e.cycles));
        check("commit_hi", HI, e.new_hi);
        check("commit_lo", LO, e.new_lo);
      end
      busy_cnt = 0;
    end
    prev_busy = Busy;
  end

  // Reference model: plain arithmetic on the MIPS rules.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int n);
    longint sp;
    longint unsigned up;
    int sa, sb_;
    hi = m_hi;
    lo = m_lo;
    n  = (op <= 3'd2) ? int'(MultN) : int'(DivN);
    sa = a;
    sb_ = b;
    case (op)
      3'd1: begin sp = longint'(sa) * longint'(sb_); {hi, lo} = sp; end
      3'd2: begin up = {32'b0, a} * {32'b0, b};      {hi, lo} = up; end
      3'd3: if (b != 0) begin lo = sa / sb_; hi = sa % sb_; end
      default: if (b != 0) begin lo = a / b; hi = a % b; end
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st);
    exp_t e;
    logic launch;
    launch = st && (op >= 3'd1) && (op <= 3'd4);
    @(negedge clk);
    Start = st; MDOp = op; A = a; B = b;
    if (launch) begin
      e.old_hi = m_hi;
      e.old_lo = m_lo;
      model(op, a, b, e.new_hi, e.new_lo, e.cycles);
      m_hi = e.new_hi;
      m_lo = e.new_lo;
      sb.push_back(e);
    end else if (op == 3'd5) m_hi = a;
    else if (op == 3'd6) m_lo = a;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0;
    if (!launch) begin
      check("nolaunch_busy", 32'(Busy), 32'd0);
      check("move_hi", HI, m_hi);
      check("move_lo", LO, m_lo);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Busy === 1'b0 && sb.size() == 0) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
    sb.delete();
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    exp_t        e;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    reset = 1'b0;

    issue(3'd1, 32'hFFFFFFFD, 32'h5, 1'b1); wait_idle();
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFF1);
    issue(3'd2, 32'hFFFFFFFD, 32'h5, 1'b1); wait_idle();
    check("multu_hi", HI, 32'h4);
    check("multu_lo", LO, 32'hFFFFFFF1);
    issue(3'd3, 32'hFFFFFFF9, 32'h2, 1'b1); wait_idle();
    check("div_hi", HI, 32'hFFFFFFFF);
    check("div_lo", LO, 32'hFFFFFFFD);
    issue(3'd4, 32'h7, 32'h2, 1'b1); wait_idle();
    check("divu_hi", HI, 32'h1);
    check("divu_lo", LO, 32'h3);

    issue(3'd5, 32'h12345678, 32'h0, 1'b0);
    check("mthi_val", HI, 32'h12345678);

    // mtlo while a div is running must be ignored.
    issue(3'd4, 32'd100, 32'd7, 1'b1);
    @(negedge clk);
    MDOp = 3'd6; A = 32'hDEADBEEF;
    @(negedge clk);
    MDOp = 3'd0;
    wait_idle();
    check("mtlo_in_run_lo", LO, 32'd14);

    // Divide by zero keeps preloaded HI/LO.
    issue(3'd5, 32'hAAAA5555, 32'h0, 1'b0);
    issue(3'd6, 32'h5555AAAA, 32'h0, 1'b0);
    issue(3'd3, 32'h1234, 32'h0, 1'b1); wait_idle();
    check("div0_hi", HI, 32'hAAAA5555);
    check("div0_lo", LO, 32'h5555AAAA);

    // Start with non-launching ops.
    issue(3'd0, 32'h1, 32'h1, 1'b1);
    issue(3'd7, 32'h1, 32'h1, 1'b1);
    issue(3'd5, 32'hCAFEF00D, 32'h1, 1'b1);

    // Back-to-back launches: next Start in first non-busy cycle.
    issue(3'd1, 32'h7, 32'h9, 1'b1);
    repeat (MultN - 1) @(negedge clk);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_idle();

    // Reset in the third busy cycle discards the pending mult.
    @(negedge clk);
    Start = 1'b1; MDOp = 3'd1; A = 32'h11111111; B = 32'h3;
    e.old_hi = m_hi; e.old_lo = m_lo; e.new_hi = 32'h0; e.new_lo = 32'h0; e.cycles = 3;
    sb.push_back(e);
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_busy", 32'(Busy), 32'd0);
      check("post_rst_hi", HI, 32'h0);
      check("post_rst_lo", LO, 32'h0);
    end

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if (op == 3'd3 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'h1;
      issue(op, a, b, 1'b1);
      wait_idle();
      check("rand_hi", HI, m_hi);
      check("rand_lo", LO, m_lo);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
